// File: rtl/i2c_burst_sequencer_pkg.sv
// Shared encodings for the I2C command sequencer: FSM states, op codes, defaults.
package i2c_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_REQ,
    ST_WR_BUSY,
    ST_PTR_REQ,
    ST_PTR_BUSY,
    ST_RD_REQ,
    ST_RD_BUSY,
    ST_RESP
  } state_t;

  localparam logic I2C_OP_WR = 1'b0;
  localparam logic I2C_OP_RD = 1'b1;

  localparam int I2C_TIMEOUT_DEFAULT = 4096;

  // States in which the sequencer is waiting on the byte controller.
  function automatic logic is_wait_state(state_t s);
    return s inside {ST_WR_REQ, ST_WR_BUSY, ST_PTR_REQ, ST_PTR_BUSY, ST_RD_REQ, ST_RD_BUSY};
  endfunction

endpackage

// File: rtl/i2c_burst_sequencer_sync_2ff.sv
// Generic 1-bit two-flop synchronizer with a synchronous active-low reset value.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (!rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/i2c_burst_sequencer.sv
// Command sequencer in front of the I2C byte controller: single writes and
// pointer-write/byte-read bursts, with a timeout so a stuck controller cannot hang it.
//
// state    | meaning
// IDLE     | waiting for a command (needs controller ready)
// WR_REQ   | write byte requested, enable high until controller starts
// WR_BUSY  | write byte in flight
// PTR_REQ  | register pointer write requested
// PTR_BUSY | pointer write in flight
// RD_REQ   | byte read requested
// RD_BUSY  | byte read in flight
// RESP     | response held until consumer takes it
module i2c_burst_sequencer
  import i2c_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = I2C_TIMEOUT_DEFAULT,
  parameter int LEN_W          = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_op,
  input  logic [6:0]       cmd_dev,
  input  logic [7:0]       cmd_reg,
  input  logic [7:0]       cmd_wdata,
  input  logic [LEN_W-1:0] cmd_len,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [7:0]       rsp_data,
  output logic             rsp_last,
  output logic             rsp_err,
  output logic             i2c_enable,
  output logic             i2c_rw,
  output logic [6:0]       i2c_addr,
  output logic [7:0]       i2c_data_in,
  input  logic             i2c_ready,
  input  logic [7:0]       i2c_data_out
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  state_t           state;
  logic             ready_s;
  logic [CNT_W-1:0] wait_cnt;
  logic [7:0]       ptr;
  logic [LEN_W-1:0] remaining;
  logic             timed_out;

  sync_2ff #(.RST_VAL(1'b0)) u_ready_sync (
    .clk (clk),
    .rst (rst),
    .d   (i2c_ready),
    .q   (ready_s)
  );

  assign cmd_ready = (state == ST_IDLE) && ready_s;
  assign timed_out = (wait_cnt == CNT_W'(TIMEOUT_CYCLES));

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= ST_IDLE;
      wait_cnt    <= '0;
      ptr         <= '0;
      remaining   <= '0;
      i2c_enable  <= 1'b0;
      i2c_rw      <= 1'b0;
      i2c_addr    <= '0;
      i2c_data_in <= '0;
      rsp_valid   <= 1'b0;
      rsp_data    <= '0;
      rsp_last    <= 1'b0;
      rsp_err     <= 1'b0;
    end else if (is_wait_state(state) && timed_out) begin
      // Abort discards whatever is left of the burst.
      state      <= ST_RESP;
      i2c_enable <= 1'b0;
      rsp_valid  <= 1'b1;
      rsp_data   <= '0;
      rsp_last   <= 1'b1;
      rsp_err    <= 1'b1;
    end else begin
      wait_cnt <= wait_cnt + CNT_W'(1);
      case (state)
        ST_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            wait_cnt   <= '0;
            i2c_enable <= 1'b1;
            i2c_rw     <= 1'b0;
            i2c_addr   <= cmd_dev;
            ptr        <= cmd_reg;
            remaining  <= (cmd_len == '0) ? LEN_W'(1) : cmd_len;
            if (cmd_op == I2C_OP_WR) begin
              state       <= ST_WR_REQ;
              i2c_data_in <= cmd_wdata;
            end else begin
              state       <= ST_PTR_REQ;
              i2c_data_in <= cmd_reg;
            end
          end
        end
        ST_WR_REQ: begin
          if (!ready_s) begin
            state      <= ST_WR_BUSY;
            i2c_enable <= 1'b0;
            wait_cnt   <= '0;
          end
        end
        ST_WR_BUSY: begin
          if (ready_s) begin
            state     <= ST_RESP;
            rsp_valid <= 1'b1;
            rsp_data  <= '0;
            rsp_last  <= 1'b1;
            rsp_err   <= 1'b0;
          end
        end
        ST_PTR_REQ: begin
          if (!ready_s) begin
            state      <= ST_PTR_BUSY;
            i2c_enable <= 1'b0;
            wait_cnt   <= '0;
          end
        end
        ST_PTR_BUSY: begin
          if (ready_s) begin
            state      <= ST_RD_REQ;
            i2c_enable <= 1'b1;
            i2c_rw     <= 1'b1;
            wait_cnt   <= '0;
          end
        end
        ST_RD_REQ: begin
          if (!ready_s) begin
            state      <= ST_RD_BUSY;
            i2c_enable <= 1'b0;
            wait_cnt   <= '0;
          end
        end
        ST_RD_BUSY: begin
          if (ready_s) begin
            state     <= ST_RESP;
            rsp_valid <= 1'b1;
            rsp_data  <= i2c_data_out;
            rsp_last  <= (remaining == LEN_W'(1));
            rsp_err   <= 1'b0;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            if (rsp_last) begin
              state <= ST_IDLE;
            end else begin
              state       <= ST_PTR_REQ;
              ptr         <= ptr + 8'd1;
              remaining   <= remaining - LEN_W'(1);
              i2c_enable  <= 1'b1;
              i2c_rw      <= 1'b0;
              i2c_data_in <= ptr + 8'd1;
              wait_cnt    <= '0;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_burst_sequencer.sv
// Bench for i2c_burst_sequencer: behavioural byte-controller/slave model plus
// directed and randomized commands checked against a register-map reference.
module tb_i2c_burst_sequencer;

  localparam int TO = 64;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic       cmd_op = 1'b0;
  logic [6:0] cmd_dev = '0;
  logic [7:0] cmd_reg = '0;
  logic [7:0] cmd_wdata = '0;
  logic [3:0] cmd_len = '0;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [7:0] rsp_data;
  logic       rsp_last;
  logic       rsp_err;
  logic       i2c_enable;
  logic       i2c_rw;
  logic [6:0] i2c_addr;
  logic [7:0] i2c_data_in;
  logic       i2c_ready = 1'b1;
  logic [7:0] i2c_data_out = '0;

  i2c_burst_sequencer #(.TIMEOUT_CYCLES(TO), .LEN_W(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .cmd_dev      (cmd_dev),
    .cmd_reg      (cmd_reg),
    .cmd_wdata    (cmd_wdata),
    .cmd_len      (cmd_len),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_data     (rsp_data),
    .rsp_last     (rsp_last),
    .rsp_err      (rsp_err),
    .i2c_enable   (i2c_enable),
    .i2c_rw       (i2c_rw),
    .i2c_addr     (i2c_addr),
    .i2c_data_in  (i2c_data_in),
    .i2c_ready    (i2c_ready),
    .i2c_data_out (i2c_data_out)
  );

  always #5 clk = ~clk;

  int          vectors = 0;
  int          miscompares = 0;
  int          busy_acc = 0;
  int          ctrl_mode = 0;  // 0 normal, 1 drop ready and hold low, 2 never respond
  logic [7:0]  mem [256];
  logic [7:0]  slave_ptr = 8'h00;
  logic [15:0] txn_q [$];      // {rw, addr, data} as seen by the controller

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Byte controller + register-pointer slave.
  initial begin : ctrl_model
    int d;
    int lo;
    forever begin
      tick();
      if (rst && i2c_ready && (i2c_enable === 1'b1) && ctrl_mode != 2) begin
        d = int'($urandom_range(2));
        repeat (d) tick();
        txn_q.push_back({i2c_rw, i2c_addr, (i2c_rw ? 8'h00 : i2c_data_in)});
        if (!i2c_rw) slave_ptr = i2c_data_in;
        i2c_ready = 1'b0;
        if (ctrl_mode == 1) begin
          wait (ctrl_mode == 0);
        end else begin
          lo = int'($urandom_range(12, 5));
          repeat (lo) tick();
        end
        if (i2c_rw) i2c_data_out = mem[slave_ptr];
        i2c_ready = 1'b1;
      end
    end
  end

  task automatic send_cmd(input logic op, input logic [6:0] dev, input logic [7:0] rg,
                          input logic [7:0] wd, input logic [3:0] len);
    bit ok;
    ok = 1'b0;
    cmd_op = op; cmd_dev = dev; cmd_reg = rg; cmd_wdata = wd; cmd_len = len;
    cmd_valid = 1'b1;
    for (int i = 0; i < 300 && !ok; i++) begin
      if (cmd_ready) ok = 1'b1;
      tick();
    end
    cmd_valid = 1'b0;
    check("cmd_accept", 32'(ok), 32'd1);
    check("enable_after_accept", 32'(i2c_enable), 32'd1);
  endtask

  task automatic get_rsp(output logic [7:0] d, output logic l, output logic e, output bit got);
    got = 1'b0; d = '0; l = 1'b0; e = 1'b0;
    for (int i = 0; i < 3000 && !got; i++) begin
      rsp_ready = 1'($urandom_range(1));
      cmd_valid = 1'($urandom_range(1));
      if (cmd_valid && cmd_ready) busy_acc++;
      if (rsp_valid && rsp_ready) begin
        d = rsp_data; l = rsp_last; e = rsp_err; got = 1'b1;
      end
      tick();
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b0;
  endtask

  task automatic run_cmd(input logic op, input logic [6:0] dev, input logic [7:0] rg,
                         input logic [7:0] wd, input logic [3:0] len, input int stall_at);
    int n;
    int ntx;
    logic [7:0]  d;
    logic        l;
    logic        e;
    bit          got;
    logic [15:0] exp_t;
    logic [15:0] act_t;
    logic [7:0]  p;
    txn_q.delete();
    busy_acc = 0;
    n = (op == 1'b0) ? 1 : ((len == 4'd0) ? 1 : int'(len));
    send_cmd(op, dev, rg, wd, len);
    for (int i = 0; i < n; i++) begin
      if (i == stall_at) begin : stall
        int sz;
        int bad;
        logic [7:0] snap;
        rsp_ready = 1'b0;
        for (int k = 0; k < 3000 && !rsp_valid; k++) tick();
        snap = rsp_data;
        sz = txn_q.size();
        bad = 0;
        repeat (200) begin
          tick();
          if (!rsp_valid || rsp_data !== snap || i2c_enable !== 1'b0 || txn_q.size() != sz) bad++;
        end
        check("bp_hold", 32'(bad), 32'd0);
      end
      get_rsp(d, l, e, got);
      p = rg + 8'(i);
      check($sformatf("rsp%0d_got", i), 32'(got), 32'd1);
      check($sformatf("rsp%0d_data", i), 32'(d), (op == 1'b1) ? 32'(mem[p]) : 32'd0);
      check($sformatf("rsp%0d_last", i), 32'(l), 32'(i == n - 1));
      check($sformatf("rsp%0d_err", i), 32'(e), 32'd0);
    end
    ntx = (op == 1'b1) ? 2 * n : 1;
    check("txn_count", 32'(txn_q.size()), 32'(ntx));
    for (int j = 0; j < ntx; j++) begin
      p = rg + 8'(j / 2);
      if (op == 1'b0)  exp_t = {1'b0, dev, wd};
      else if (j % 2 == 0) exp_t = {1'b0, dev, p};
      else exp_t = {1'b1, dev, 8'h00};
      act_t = (j < txn_q.size()) ? txn_q[j] : 16'hFFFF;
      check($sformatf("txn%0d", j), 32'(act_t), 32'(exp_t));
    end
    check("busy_ignores_cmd", 32'(busy_acc), 32'd0);
  endtask

  initial begin : main
    int cyc;
    int acc;
    bit got;
    logic [7:0] d;
    logic l;
    logic e;
    int len;
    int stall;

    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    mem[8'h3B] = 8'h11; mem[8'h3C] = 8'h22; mem[8'h3D] = 8'h33;

    // Reset state and ready synchronizer latency.
    rst = 1'b0;
    tick(); tick(); tick();
    check("reset_outputs", 32'({cmd_ready, rsp_valid, rsp_data, rsp_last, rsp_err,
                                i2c_enable, i2c_rw, i2c_addr, i2c_data_in}), 32'd0);
    rst = 1'b1;
    tick();
    check("cmd_ready_1cyc", 32'(cmd_ready), 32'd0);
    tick();
    check("cmd_ready_2cyc", 32'(cmd_ready), 32'd1);

    // Single write: address byte 0xD0 then data 0x6B.
    run_cmd(1'b0, 7'h68, 8'h00, 8'h6B, 4'd0, -1);
    check("wr_addr_byte", (txn_q.size() > 0) ? 32'({txn_q[0][14:8], txn_q[0][15]}) : 32'hFFFF, 32'hD0);

    run_cmd(1'b1, 7'h68, 8'h3B, 8'h00, 4'd3, -1);
    run_cmd(1'b1, 7'h21, 8'hFF, 8'h00, 4'd2, -1);
    run_cmd(1'b1, 7'h21, 8'h80, 8'h00, 4'd0, -1);
    run_cmd(1'b1, 7'h68, 8'h40, 8'h00, 4'd4, 2);

    // Timeout while the controller never starts (REQ wait).
    ctrl_mode = 2;
    txn_q.delete();
    send_cmd(1'b1, 7'h55, 8'h10, 8'h00, 4'd3);
    cyc = 0;
    while (!rsp_valid && cyc < 300) begin tick(); cyc++; end
    check("to_req_window", 32'(cyc >= TO && cyc <= TO + 4), 32'd1);
    check("to_req_fields", 32'({rsp_valid, rsp_err, rsp_last, rsp_data, i2c_enable}),
          32'({1'b1, 1'b1, 1'b1, 8'h00, 1'b0}));
    rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
    ctrl_mode = 0;
    check("to_req_no_txn", 32'(txn_q.size()), 32'd0);

    // Timeout with controller ready stuck low (BUSY wait).
    ctrl_mode = 1;
    send_cmd(1'b1, 7'h55, 8'h20, 8'h00, 4'd3);
    cyc = 0;
    while (i2c_enable && cyc < 300) begin tick(); cyc++; end
    cyc = 0;
    while (!rsp_valid && cyc < 300) begin tick(); cyc++; end
    check("to_busy_window", 32'(cyc <= TO + 4), 32'd1);
    check("to_busy_fields", 32'({rsp_valid, rsp_err, rsp_last, rsp_data, i2c_enable}),
          32'({1'b1, 1'b1, 1'b1, 8'h00, 1'b0}));
    rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
    acc = 0;
    repeat (10) begin tick(); if (cmd_ready) acc++; end
    check("to_ready_held_off", 32'(acc), 32'd0);
    ctrl_mode = 0;
    cyc = 0;
    while (!cmd_ready && cyc < 20) begin tick(); cyc++; end
    check("to_ready_restored", 32'(cmd_ready), 32'd1);

    // Reset in the middle of a read transfer.
    txn_q.delete();
    send_cmd(1'b1, 7'h33, 8'h10, 8'h00, 4'd4);
    cyc = 0;
    while (!(txn_q.size() > 0 && txn_q[txn_q.size()-1][15] && !i2c_ready && !i2c_enable) && cyc < 2000) begin
      tick(); cyc++;
    end
    check("reached_rd_busy", 32'(cyc < 2000), 32'd1);
    rst = 1'b0;
    tick();
    check("rst_mid_outputs", 32'({i2c_enable, rsp_valid, cmd_ready}), 32'd0);
    tick();
    rst = 1'b1;
    cyc = 0;
    while (!i2c_ready && cyc < 50) begin tick(); cyc++; end
    tick(); tick(); tick();
    run_cmd(1'b1, 7'h33, 8'h3B, 8'h00, 4'd2, -1);

    // Randomized commands.
    for (int t = 0; t < 12; t++) begin
      len = int'($urandom_range(15));
      stall = ($urandom_range(3) == 0) ? int'($urandom_range(2)) : -1;
      run_cmd(1'($urandom_range(1)), 7'($urandom), 8'($urandom), 8'($urandom), 4'(len), stall);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/i2c_burst_sequencer.md
# i2c_burst_sequencer

Command sequencer directly upstream of the I2C byte controller (`i2c_controller`). It accepts register-level commands from the host/sensor logic, drives the controller's `enable`/`addr`/`rw`/`data_in` handshake, and returns read bytes as a backpressured response stream. Burst reads repeat a pointer-write then byte-read pair over consecutive registers. A timeout supervisor guarantees the block never hangs on a stuck controller.

## Interface
- `TIMEOUT_CYCLES`, default 4096: `clk` cycles allowed in any controller-wait state before abort.
- `LEN_W`, default 4: width of the burst length field.

Ports:
- `clk`  in  1  system clock, the same clock that feeds the controller's divider.
- `rst`  in  1  reset, synchronous, active-low.
- `cmd_valid`  in  1  command request.
- `cmd_ready`  out  1  command accepted when high together with `cmd_valid`.
- `cmd_op`  in  1  0 = single write (`cmd_wdata` sent as the data byte); 1 = burst read.
- `cmd_dev`  in  7  7-bit device address.
- `cmd_reg`  in  8  start register pointer (burst read).
- `cmd_wdata`  in  8  write byte.
- `cmd_len`  in  LEN_W  burst byte count; 0 is treated as 1.
- `rsp_valid`  out  1  response byte valid.
- `rsp_ready`  in  1  response consumer ready.
- `rsp_data`  out  8  read byte; 0 for write completions and errors.
- `rsp_last`  out  1  final response of the command.
- `rsp_err`  out  1  timeout abort.
- `i2c_enable`  out  1  to controller `enable`.
- `i2c_rw`  out  1  to controller `rw`.
- `i2c_addr`  out  7  to controller `addr`.
- `i2c_data_in`  out  8  to controller `data_in`.
- `i2c_ready`  in  1  from controller `ready`; treated as asynchronous.
- `i2c_data_out`  in  8  from controller `data_out`.

## Operation
- `i2c_ready` passes through a 2-flop synchronizer (`ready_s`). The synchronizer resets to 0.
- `cmd_ready = (state==IDLE) && ready_s`. On accept, latch `cmd_dev`, `cmd_reg`, `cmd_wdata`, `cmd_op`, and `remaining = max(cmd_len,1)`.
- Each controller transaction is run as a pair of states:
  - **REQ**: `i2c_enable=1`, with `i2c_addr`, `i2c_rw`, and `i2c_data_in` held stable. Exit when `ready_s==0` (transaction started).
  - **BUSY**: `i2c_enable=0`. Exit when `ready_s==1` (transaction done).
  - `i2c_enable` must be low before the controller reaches its second-ACK state, so a completed write always terminates with STOP.
- Write command (`cmd_op=0`): WR_REQ → WR_BUSY (rw=0, data=`cmd_wdata`) → RESP (data 0, last 1, err 0) → IDLE.
- Burst read (`cmd_op=1`):
  - PTR_REQ → PTR_BUSY (rw=0, data=`ptr`).
  - RD_REQ → RD_BUSY (rw=1). On exit, capture `i2c_data_out` into `rsp_data`.
  - RESP with last = (`remaining==1`).
  - On RESP handshake: if not last, `ptr <= ptr+1` (mod 256, so 0xFF wraps to 0x00), decrement `remaining`, and return to PTR_REQ. Otherwise go to IDLE.
- States: IDLE, WR_REQ, WR_BUSY, PTR_REQ, PTR_BUSY, RD_REQ, RD_BUSY, RESP.
- RESP holds `rsp_valid` and all response fields stable until `rsp_ready`. No new controller transaction is issued while in RESP.
- NACK is not observable (the controller silently STOPs). Read data after a NACK is whatever `i2c_data_out` holds, and no error is flagged.
- Timeout:
  - The wait counter clears on entry to every REQ/BUSY state.
  - If it reaches `TIMEOUT_CYCLES`, drop `i2c_enable` and go to RESP with err=1, last=1, data=0. The remaining burst is discarded.
- `cmd_valid` seen outside IDLE is ignored (not accepted).

## Timing
- Reset (`rst==0` at a `clk` edge):
  - state=IDLE, `ready_s`=0.
  - All outputs 0: `cmd_ready`, `rsp_*`, `i2c_enable`, `i2c_rw`, `i2c_addr`, `i2c_data_in`.
  - `cmd_ready` rises 2 cycles after reset release, provided `i2c_ready` is high.
- Reset mid-transaction drops `i2c_enable` the same edge. Any pending response is lost.
- Cycle latencies:
  - Accept → `i2c_enable` high: 1 cycle.
  - `i2c_ready` fall → enable low: 3 cycles (2 sync + 1 state).
  - `i2c_ready` rise → `rsp_valid` (read) or next REQ: 3 cycles.
- `i2c_addr`, `i2c_rw`, and `i2c_data_in` are registered and change only on REQ entry.

## Structure
- Shared package `i2c_pkg`: state encodings, op codes (`I2C_OP_WR=0`, `I2C_OP_RD=1`), default `TIMEOUT_CYCLES`.
- Sub-module `sync_2ff`: generic 1-bit two-flop synchronizer with synchronous active-low reset value parameter.
- Otherwise a single FSM, one wait counter (`$clog2(TIMEOUT_CYCLES+1)` bits), pointer, and remaining counter.

## Test plan
- **Single write**: bench pairs the block with `i2c_controller` and an ACKing slave model. Write dev 0x68, data 0x6B → slave sees address byte 0xD0 then 0x6B followed by STOP; one response with data 0, last 1, err 0.
- **Burst read**: dev 0x68, reg 0x3B, len 3; slave returns 0x11/0x22/0x33 → pointer writes 0x3B, 0x3C, 0x3D; responses 0x11, 0x22, 0x33 with last only on the third.
- **Pointer wrap and len 0**: reg 0xFF, len 2 → pointers 0xFF then 0x00. Separately, len 0 → exactly one response.
- **Backpressure**: hold `rsp_ready` low for 200 cycles mid-burst → `rsp_data` stable, `i2c_enable` stays 0, and no bus activity until release.
- **Timeout**: controller model holds `ready` low forever, `TIMEOUT_CYCLES=64` → `i2c_enable` drops; response err 1, last 1, data 0 within 64+4 cycles; `cmd_ready` returns once `ready` is restored.
- **Reset mid-burst**: assert `rst` low during RD_BUSY → next edge has `i2c_enable`=0 and `rsp_valid`=0; the block accepts a new command after release.
